// File: rtl/move_display_ctrl_if.sv
// Solver-result / button / display bundle for the move viewer.
// The master side drives solver results and raw buttons; the slave side drives the display.
interface move_display_ctrl_if #(
  parameter int MAX_MOVES = 31
);
  logic                     comp;
  logic [2*MAX_MOVES-1:0]   ord;
  logic [6:0]               num_moves;
  logic                     btn_next;
  logic                     btn_prev;
  logic [6:0]               seg;
  logic [3:0]               an;
  logic [6:0]               step_idx;
  logic                     last;

  modport master (output comp, ord, num_moves, btn_next, btn_prev,
                  input  seg, an, step_idx, last);
  modport slave  (input  comp, ord, num_moves, btn_next, btn_prev,
                  output seg, an, step_idx, last);
endinterface

// File: rtl/move_display_ctrl.sv
// Steps through a solved 8-puzzle move list with debounced next/prev buttons and
// shows direction letters plus the step number on a scanned 4-digit 7-segment display.

module move_btn_deb #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic press_o
);
  localparam int CW = $clog2(DEB_CYCLES) + 1;

  logic          s1_q, s2_q, acc_q, press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      acc_q   <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      press_q <= 1'b0;
      if (s2_q == acc_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        // Level has differed for DEB_CYCLES cycles: accept it; only presses emit events.
        cnt_q   <= '0;
        acc_q   <= s2_q;
        press_q <= ~s2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;
endmodule

module move_display_ctrl #(
  parameter int MAX_MOVES  = 31,
  parameter int DEB_CYCLES = 16,
  parameter int SCAN_DIV   = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  move_display_ctrl_if.slave bus
);
  localparam int         SW   = $clog2(SCAN_DIV) + 1;
  localparam logic [6:0] MAXL = 7'(MAX_MOVES);

  localparam logic [6:0] G_U = 7'b0111110, G_P = 7'b1100111, G_D = 7'b0111101,
                         G_O = 7'b0011101, G_R = 7'b0000101, G_I = 7'b0110000,
                         G_L = 7'b0001110, G_E = 7'b1001111, G_N = 7'b0010101;

  typedef enum logic [1:0] {IDLE, SHOW, DONE} state_t;

  state_t                 state_q, state_d;
  logic [6:0]             step_q, step_d, len_q, len_d;
  logic [2*MAX_MOVES-1:0] ord_q, ord_d;
  logic [SW-1:0]          scan_q;
  logic [1:0]             dig_q;
  logic [6:0]             seg_q, seg_d;
  logic [3:0]             an_q, an_d;

  logic [1:0] raw, press;
  logic       ev_nx, ev_pv;

  assign raw = {bus.btn_prev, bus.btn_next};

  move_btn_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb [1:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (raw),
    .press_o (press)
  );

  // Coincident next+prev presses cancel each other.
  assign ev_nx = press[0] & ~press[1];
  assign ev_pv = press[1] & ~press[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      len_q   <= '0;
      ord_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      len_q   <= len_d;
      ord_q   <= ord_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    len_d   = len_q;
    ord_d   = ord_q;
    if (!bus.comp) begin
      state_d = IDLE;
      step_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          ord_d = bus.ord;
          len_d = (bus.num_moves > MAXL) ? MAXL : bus.num_moves;
          if (len_d != '0) begin
            state_d = SHOW;
            step_d  = 7'd1;
          end else begin
            state_d = DONE;
            step_d  = '0;
          end
        end
        SHOW: begin
          if (ev_nx) begin
            if (step_q < len_q) step_d  = step_q + 7'd1;
            else                state_d = DONE;
          end else if (ev_pv && step_q > 7'd1) begin
            step_d = step_q - 7'd1;
          end
        end
        DONE: if (ev_pv && len_q != '0) state_d = SHOW;
        default: begin
          state_d = IDLE;
          step_d  = '0;
        end
      endcase
    end
  end

  function automatic logic [6:0] tens(input logic [6:0] v);
    logic [6:0] t;
    t = '0;
    for (int i = 1; i < 10; i++) if (v >= 7'(10 * i)) t = 7'(i);
    return t;
  endfunction

  function automatic logic [6:0] ones(input logic [6:0] v);
    return v - 7'd10 * tens(v);
  endfunction

  function automatic logic [6:0] dgl(input logic [6:0] d);
    case (d)
      7'd0: dgl = 7'b1111110;  7'd1: dgl = 7'b0110000;
      7'd2: dgl = 7'b1101101;  7'd3: dgl = 7'b1111001;
      7'd4: dgl = 7'b0110011;  7'd5: dgl = 7'b1011011;
      7'd6: dgl = 7'b1011111;  7'd7: dgl = 7'b1110000;
      7'd8: dgl = 7'b1111111;  7'd9: dgl = 7'b1111011;
      default: dgl = 7'b0000000;
    endcase
  endfunction

  logic [1:0]      mv;
  logic [3:0][6:0] digs;

  always_comb begin
    mv = 2'b00;
    for (int k = 0; k < MAX_MOVES; k++)
      if (step_q == 7'(k + 1)) mv = ord_q[2*k +: 2];
  end

  always_comb begin
    digs = '0;
    case (state_q)
      SHOW: begin
        case (mv)
          2'b00:   begin digs[3] = G_U; digs[2] = G_P; end
          2'b01:   begin digs[3] = G_D; digs[2] = G_O; end
          2'b10:   begin digs[3] = G_R; digs[2] = G_I; end
          default: begin digs[3] = G_L; digs[2] = G_E; end
        endcase
        digs[1] = dgl(tens(step_q));
        digs[0] = dgl(ones(step_q));
      end
      DONE: begin
        digs[3] = G_E;
        digs[2] = G_N;
        digs[1] = dgl(tens(len_q));
        digs[0] = dgl(ones(len_q));
      end
      default: digs = '0;
    endcase
    seg_d = digs[dig_q];
    an_d  = 4'b0001 << dig_q;
  end

  // seg and an share one register stage so the lit digit always gets its own pattern.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_q <= '0;
      dig_q  <= '0;
      seg_q  <= '0;
      an_q   <= 4'b0001;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
      if (scan_q == SW'(SCAN_DIV - 1)) begin
        scan_q <= '0;
        dig_q  <= dig_q + 2'd1;
      end else begin
        scan_q <= scan_q + 1'b1;
      end
    end
  end

  assign bus.seg      = seg_q;
  assign bus.an       = an_q;
  assign bus.step_idx = step_q;
  assign bus.last     = (state_q == DONE);
endmodule
